microcode_sequencer: RTL and testbench
======================================

Name: microcode_sequencer

Overview:
- Execute-phase control unit for the 8-bit SAP processor.
- Steps a T-state counter through fetch (T0–T1) and per-opcode execute states (T2–T4).
- Decodes the IR opcode and drives one-cycle control strobes to PC, MAR, RAM, IR, A, B, ALU, flags and output register.
- Sits between the IR/flag registers and the shared 8-bit bus datapath, and supersedes the fetch-only controller as the sole source of bus-enable and load signals.

Parameters:
- OPC_W, 4, opcode width (IR[7:4]).
- OPR_W, 4, operand/address width (IR[3:0]); sets the width of the ir_out bus drive.

Ports:
- clk  in  1  system clock, all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- run  in  1  allow start of a new instruction at T0
- ir_opcode  in  OPC_W  opcode field from IR
- carry_flag  in  1  registered ALU carry
- zero_flag  in  1  registered ALU zero
- pc_out  out  1  PC drives bus
- pc_inc  out  1  PC increment
- pc_load  out  1  PC loads from bus
- mar_load  out  1  MAR loads from bus
- ram_read  out  1  RAM drives bus
- ram_write  out  1  RAM writes bus value at MAR
- ir_load  out  1  IR loads from bus
- ir_out  out  1  IR operand (zero-extended) drives bus
- a_load  out  1  A loads from bus
- a_out  out  1  A drives bus
- b_load  out  1  B loads from bus
- alu_out  out  1  ALU result drives bus
- alu_sub  out  1  ALU subtract select
- flags_load  out  1  flag register captures carry/zero
- out_load  out  1  output register loads from bus
- halted  out  1  HLT executed
- tstate  out  3  current T-state (0–4), debug/visibility

Behaviour:
- State register: T0, T1, T2, T3, T4, HALT. Control outputs are combinational from state plus ir_opcode.
- Reset: rst sampled on posedge. Next state is T0, halted=0, tstate=0. While rst=1, all strobes are forced 0 (including the T0 strobes). Reset mid-instruction aborts it with no further strobes.
- T0: if run=1, assert pc_out and mar_load, then go to T1. If run=0, all strobes are 0 and the block stays in T0. run is ignored in all other states.
- T1: assert ram_read, ir_load and pc_inc, then go to T2. ir_opcode is valid from T2 onward.
- Execute strobes per opcode (a single strobe row per T-state). After the last listed state the next state is T0.
  - 0 NOP: T2 none.
  - 1 LDA: T2 ir_out+mar_load. T3 ram_read+a_load.
  - 2 ADD: T2 ir_out+mar_load. T3 ram_read+b_load. T4 alu_out+a_load+flags_load.
  - 3 SUB: same as ADD, with alu_sub=1 in T4 only.
  - 4 STA: T2 ir_out+mar_load. T3 a_out+ram_write.
  - 5 LDI: T2 ir_out+a_load.
  - 6 JMP: T2 ir_out+pc_load.
  - 7 JC: T2 ir_out, plus pc_load only if carry_flag=1 in that cycle.
  - 8 JZ: T2 ir_out, plus pc_load only if zero_flag=1.
  - E OUT: T2 a_out+out_load.
  - F HLT: T2 no strobes, next state HALT.
  - 9–D (undefined): execute as NOP.
- HALT: all strobes 0, halted=1, tstate=7. Exit only via rst.
- Bus exclusivity invariant: at most one of pc_out, ram_read, ir_out, a_out, alu_out is 1 in any cycle.
- Instruction length in cycles: NOP/LDI/JMP/JC/JZ/OUT/undefined = 3; LDA/STA = 4; ADD/SUB = 5.
- tstate encodes T0–T4 as 0–4.

Test Plan:
- rst held 3 cycles, then released with run=1 -> all strobes 0 during reset; first post-reset cycle tstate=0 with pc_out=mar_load=1; next cycle ram_read=ir_load=pc_inc=1.
- ir_opcode=2 (ADD) -> tstates 0,1,2,3,4,0; T4 has alu_out=a_load=flags_load=1 and alu_sub=0; SUB (3) is identical except alu_sub=1 in T4 only.
- JC with carry_flag=0, then JC with carry_flag=1 -> pc_load=0 in T2 of the first and pc_load=1 in T2 of the second; both instructions return to T0 after 3 cycles.
- run=0 at T0 for 4 cycles, then run=1 -> tstate stays 0 with all strobes 0; fetch resumes the cycle run rises; dropping run at T2 of an LDA does not stall it.
- HLT (F) -> halted=1 from the cycle after T2; no strobes for 10 cycles; rst clears halted and restarts at T0.
- Assert rst at T3 of STA -> no ram_write that cycle; sequencer is at T0 the next cycle; random opcode stream checked for the bus exclusivity invariant every cycle.

Source files
------------

// File: rtl/microcode_sequencer_if.sv
// Control bundle between the SAP sequencer and the shared 8-bit bus datapath.
// master: the sequencer. It samples run, opcode and flags and drives every
//         strobe, plus halted and tstate.
// slave : the datapath side. It drives run, opcode and flags and receives
//         the strobes.
interface microcode_sequencer_if #(
    parameter int OPC_W = 4
);
    logic             run;
    logic [OPC_W-1:0] ir_opcode;
    logic             carry_flag;
    logic             zero_flag;

    logic pc_out;
    logic pc_inc;
    logic pc_load;
    logic mar_load;
    logic ram_read;
    logic ram_write;
    logic ir_load;
    logic ir_out;
    logic a_load;
    logic a_out;
    logic b_load;
    logic alu_out;
    logic alu_sub;
    logic flags_load;
    logic out_load;
    logic       halted;
    logic [2:0] tstate;

    modport master (
        input  run, ir_opcode, carry_flag, zero_flag,
        output pc_out, pc_inc, pc_load, mar_load, ram_read, ram_write,
               ir_load, ir_out, a_load, a_out, b_load, alu_out, alu_sub,
               flags_load, out_load, halted, tstate
    );

    modport slave (
        output run, ir_opcode, carry_flag, zero_flag,
        input  pc_out, pc_inc, pc_load, mar_load, ram_read, ram_write,
               ir_load, ir_out, a_load, a_out, b_load, alu_out, alu_sub,
               flags_load, out_load, halted, tstate
    );
endinterface

// File: rtl/microcode_sequencer.sv
// SAP execute-phase control unit. It steps T0..T4 and decodes the IR opcode
// into one-cycle datapath strobes. All strobes are combinational from the
// state and the opcode.
// Ports: clk, rst (synchronous, active-high), bus (microcode_sequencer_if
//        master: run, opcode and flags in; strobes, halted and tstate out).
//
// state | meaning
// T0    | fetch: PC -> MAR (only when run=1)
// T1    | fetch: RAM -> IR, PC++
// T2    | execute step 1 (every opcode)
// T3    | execute step 2 (LDA, STA, ADD, SUB)
// T4    | execute step 3 (ADD, SUB)
// HALT  | HLT executed, only rst leaves
module microcode_sequencer #(
    parameter int OPC_W = 4,
    parameter int OPR_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    microcode_sequencer_if.master bus
);
    // The operand width only sizes the datapath's IR-to-bus drive.
    // A width of zero would make that drive meaningless.
    if (OPR_W < 1) begin : g_bad_opr_w
        $error("microcode_sequencer: OPR_W must be at least 1");
    end

    // The encoding is the tstate value, so HALT reads back as 7.
    typedef enum logic [2:0] {
        T0   = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        T4   = 3'd4,
        HALT = 3'd7
    } state_t;

    localparam logic [OPC_W-1:0] OP_LDA = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_STA = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_LDI = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_JC  = OPC_W'(7);
    localparam logic [OPC_W-1:0] OP_JZ  = OPC_W'(8);
    localparam logic [OPC_W-1:0] OP_OUT = OPC_W'(14);
    localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(15);

    state_t state, state_nxt;

    always_ff @(posedge clk) begin
        if (rst) state <= T0;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        bus.pc_out     = 1'b0;
        bus.pc_inc     = 1'b0;
        bus.pc_load    = 1'b0;
        bus.mar_load   = 1'b0;
        bus.ram_read   = 1'b0;
        bus.ram_write  = 1'b0;
        bus.ir_load    = 1'b0;
        bus.ir_out     = 1'b0;
        bus.a_load     = 1'b0;
        bus.a_out      = 1'b0;
        bus.b_load     = 1'b0;
        bus.alu_out    = 1'b0;
        bus.alu_sub    = 1'b0;
        bus.flags_load = 1'b0;
        bus.out_load   = 1'b0;

        unique case (state)
            T0: begin
                if (bus.run) begin
                    bus.pc_out   = 1'b1;
                    bus.mar_load = 1'b1;
                    state_nxt    = T1;
                end
            end
            T1: begin
                bus.ram_read = 1'b1;
                bus.ir_load  = 1'b1;
                bus.pc_inc   = 1'b1;
                state_nxt    = T2;
            end
            T2: begin
                state_nxt = T0;
                case (bus.ir_opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        bus.ir_out   = 1'b1;
                        bus.mar_load = 1'b1;
                        state_nxt    = T3;
                    end
                    OP_LDI: begin
                        bus.ir_out = 1'b1;
                        bus.a_load = 1'b1;
                    end
                    OP_JMP: begin
                        bus.ir_out  = 1'b1;
                        bus.pc_load = 1'b1;
                    end
                    OP_JC: begin
                        bus.ir_out  = 1'b1;
                        bus.pc_load = bus.carry_flag;
                    end
                    OP_JZ: begin
                        bus.ir_out  = 1'b1;
                        bus.pc_load = bus.zero_flag;
                    end
                    OP_OUT: begin
                        bus.a_out    = 1'b1;
                        bus.out_load = 1'b1;
                    end
                    OP_HLT: state_nxt = HALT;
                    default: ;  // NOP and the undefined opcodes
                endcase
            end
            T3: begin
                state_nxt = T0;
                case (bus.ir_opcode)
                    OP_LDA: begin
                        bus.ram_read = 1'b1;
                        bus.a_load   = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        bus.ram_read = 1'b1;
                        bus.b_load   = 1'b1;
                        state_nxt    = T4;
                    end
                    OP_STA: begin
                        bus.a_out     = 1'b1;
                        bus.ram_write = 1'b1;
                    end
                    default: ;
                endcase
            end
            T4: begin
                state_nxt = T0;
                if (bus.ir_opcode == OP_ADD || bus.ir_opcode == OP_SUB) begin
                    bus.alu_out    = 1'b1;
                    bus.a_load     = 1'b1;
                    bus.flags_load = 1'b1;
                    bus.alu_sub    = (bus.ir_opcode == OP_SUB);
                end
            end
            HALT: state_nxt = HALT;
            default: state_nxt = T0;
        endcase

        // Reset overrides even the T0 fetch strobes. This lets an aborted
        // instruction (for example an STA caught in T3) write nothing.
        if (rst) begin
            bus.pc_out     = 1'b0;
            bus.pc_inc     = 1'b0;
            bus.pc_load    = 1'b0;
            bus.mar_load   = 1'b0;
            bus.ram_read   = 1'b0;
            bus.ram_write  = 1'b0;
            bus.ir_load    = 1'b0;
            bus.ir_out     = 1'b0;
            bus.a_load     = 1'b0;
            bus.a_out      = 1'b0;
            bus.b_load     = 1'b0;
            bus.alu_out    = 1'b0;
            bus.alu_sub    = 1'b0;
            bus.flags_load = 1'b0;
            bus.out_load   = 1'b0;
        end
    end

    assign bus.halted = (state == HALT);
    assign bus.tstate = state;
endmodule

// File: tb/tb_microcode_sequencer.sv
// Scoreboard bench for microcode_sequencer. Directed cycles push their
// hand-computed control word into a queue. A monitor on the falling edge pops
// one entry per cycle and compares it, and it also checks bus exclusivity on
// every cycle.
module tb_microcode_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    microcode_sequencer_if #(.OPC_W(4)) bus ();
    microcode_sequencer #(.OPC_W(4), .OPR_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    localparam logic [14:0] NONE = 15'd0;
    localparam logic [14:0] PC_OUT = 15'd1,     PC_INC = 15'd2,     PC_LOAD = 15'd4;
    localparam logic [14:0] MAR_LOAD = 15'd8,   RAM_READ = 15'd16,  RAM_WRITE = 15'd32;
    localparam logic [14:0] IR_LOAD = 15'd64,   IR_OUT = 15'd128,   A_LOAD = 15'd256;
    localparam logic [14:0] A_OUT = 15'd512,    B_LOAD = 15'd1024,  ALU_OUT = 15'd2048;
    localparam logic [14:0] ALU_SUB = 15'd4096, FLAGS_LOAD = 15'd8192, OUT_LOAD = 15'd16384;

    typedef struct {
        logic [18:0] val;
        logic [18:0] mask;
        string       name;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;

    wire [14:0] act_strobes = {bus.out_load, bus.flags_load, bus.alu_sub, bus.alu_out,
                               bus.b_load, bus.a_out, bus.a_load, bus.ir_out, bus.ir_load,
                               bus.ram_write, bus.ram_read, bus.mar_load, bus.pc_load,
                               bus.pc_inc, bus.pc_out};
    wire [18:0] act = {bus.tstate, bus.halted, act_strobes};

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if ((act & e.mask) !== (e.val & e.mask)) begin
                bad++;
                $display("FAIL %s: got ts=%0d halted=%b strobes=%h, want ts=%0d halted=%b strobes=%h",
                         e.name, act[18:16], act[15], act[14:0],
                         e.val[18:16], e.val[15], e.val[14:0]);
            end
        end
        total++;
        if ($countones({bus.pc_out, bus.ram_read, bus.ir_out, bus.a_out, bus.alu_out}) > 1) begin
            bad++;
            $display("FAIL bus_excl: got drivers=%b, want at most one set",
                     {bus.pc_out, bus.ram_read, bus.ir_out, bus.a_out, bus.alu_out});
        end
    end

    task automatic drive(input logic r, input logic rn, input logic [3:0] op,
                         input logic cf, input logic zf);
        @(posedge clk);
        #1;
        rst            = r;
        bus.run        = rn;
        bus.ir_opcode  = op;
        bus.carry_flag = cf;
        bus.zero_flag  = zf;
    endtask

    // One cycle. When chk_state is 0, only the strobes are compared.
    task automatic cyc(input logic r, input logic rn, input logic [3:0] op,
                       input logic cf, input logic zf, input logic [2:0] ts,
                       input logic hl, input logic [14:0] st, input logic chk_state,
                       input string nm);
        exp_t e;
        drive(r, rn, op, cf, zf);
        e.val  = {ts, hl, st};
        e.mask = chk_state ? 19'h7ffff : 19'h07fff;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic fetch(input logic [3:0] op, input string nm);
        cyc(0, 1, op, 0, 0, 3'd0, 0, PC_OUT | MAR_LOAD, 1, {nm, "_t0"});
        cyc(0, 1, op, 0, 0, 3'd1, 0, RAM_READ | IR_LOAD | PC_INC, 1, {nm, "_t1"});
    endtask

    task automatic short_instr(input logic [3:0] op, input logic cf, input logic zf,
                               input logic [14:0] t2, input string nm);
        fetch(op, nm);
        cyc(0, 1, op, cf, zf, 3'd2, 0, t2, 1, {nm, "_t2"});
    endtask

    initial begin
        bus.run = 1'b1; bus.ir_opcode = 4'd0; bus.carry_flag = 1'b0; bus.zero_flag = 1'b0;

        for (int i = 0; i < 3; i++) cyc(1, 1, 4'd0, 0, 0, 3'd0, 0, NONE, 0, "reset");

        // ADD, then SUB
        fetch(4'd2, "add");
        cyc(0, 1, 4'd2, 0, 0, 3'd2, 0, IR_OUT | MAR_LOAD, 1, "add_t2");
        cyc(0, 1, 4'd2, 0, 0, 3'd3, 0, RAM_READ | B_LOAD, 1, "add_t3");
        cyc(0, 1, 4'd2, 0, 0, 3'd4, 0, ALU_OUT | A_LOAD | FLAGS_LOAD, 1, "add_t4");
        fetch(4'd3, "sub");
        cyc(0, 1, 4'd3, 0, 0, 3'd2, 0, IR_OUT | MAR_LOAD, 1, "sub_t2");
        cyc(0, 1, 4'd3, 0, 0, 3'd3, 0, RAM_READ | B_LOAD, 1, "sub_t3");
        cyc(0, 1, 4'd3, 0, 0, 3'd4, 0, ALU_OUT | A_LOAD | FLAGS_LOAD | ALU_SUB, 1, "sub_t4");

        // Conditional jumps and the other three-cycle opcodes
        short_instr(4'd7, 0, 1, IR_OUT,           "jc_nc");
        short_instr(4'd7, 1, 0, IR_OUT | PC_LOAD, "jc_c");
        short_instr(4'd8, 1, 0, IR_OUT,           "jz_nz");
        short_instr(4'd8, 0, 1, IR_OUT | PC_LOAD, "jz_z");
        short_instr(4'd5, 0, 0, IR_OUT | A_LOAD,  "ldi");
        short_instr(4'd6, 0, 0, IR_OUT | PC_LOAD, "jmp");
        short_instr(4'he, 0, 0, A_OUT | OUT_LOAD, "out");
        short_instr(4'd0, 1, 1, NONE,             "nop");
        short_instr(4'ha, 1, 1, NONE,             "undef");

        // run low at T0 stalls. Dropping run mid-LDA does not stall it.
        for (int i = 0; i < 4; i++) cyc(0, 0, 4'd1, 0, 0, 3'd0, 0, NONE, 1, "idle");
        fetch(4'd1, "lda");
        cyc(0, 0, 4'd1, 0, 0, 3'd2, 0, IR_OUT | MAR_LOAD, 1, "lda_t2");
        cyc(0, 0, 4'd1, 0, 0, 3'd3, 0, RAM_READ | A_LOAD, 1, "lda_t3");
        cyc(0, 0, 4'd1, 0, 0, 3'd0, 0, NONE, 1, "lda_idle");

        // Full STA, then an STA aborted by reset in T3
        fetch(4'd4, "sta");
        cyc(0, 1, 4'd4, 0, 0, 3'd2, 0, IR_OUT | MAR_LOAD, 1, "sta_t2");
        cyc(0, 1, 4'd4, 0, 0, 3'd3, 0, A_OUT | RAM_WRITE, 1, "sta_t3");
        fetch(4'd4, "sta_abort");
        cyc(0, 1, 4'd4, 0, 0, 3'd2, 0, IR_OUT | MAR_LOAD, 1, "sta_abort_t2");
        cyc(1, 1, 4'd4, 0, 0, 3'd3, 0, NONE, 1, "sta_abort_rst");
        short_instr(4'd5, 0, 0, IR_OUT | A_LOAD, "post_abort");

        // HLT, then recovery through reset
        short_instr(4'hf, 0, 0, NONE, "hlt");
        for (int i = 0; i < 10; i++) cyc(0, 1, 4'hf, 1, 1, 3'd7, 1, NONE, 1, "halted");
        cyc(1, 1, 4'd0, 0, 0, 3'd7, 1, NONE, 0, "halt_rst");
        short_instr(4'd0, 0, 0, NONE, "after_halt");

        // Random opcode stream. Only the exclusivity check runs here.
        for (int i = 0; i < 400; i++)
            drive(($urandom_range(0, 24) == 0), $urandom_range(0, 1) != 0,
                  4'($urandom_range(0, 15)), $urandom_range(0, 1) != 0,
                  $urandom_range(0, 1) != 0);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending entries, want 0", sb.size());
        end
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
